// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/UART sequencer: FSM state encoding,
// ALU load-strobe one-hot constants and ALU operation codes.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_SEND    = 3'd5
    } seq_state_t;

    // One-hot load strobes toward the ALU (shared with the ALU bench)
    localparam logic [2:0] LOAD_A  = 3'b001;
    localparam logic [2:0] LOAD_B  = 3'b010;
    localparam logic [2:0] LOAD_OP = 3'b100;

    // ALU operation codes (low NB_OPERATION bits of the op byte)
    localparam logic [5:0] OP_ADD = 6'h08;
    localparam logic [5:0] OP_SUB = 6'h0A;
    localparam logic [5:0] OP_AND = 6'h0C;
    localparam logic [5:0] OP_OR  = 6'h0D;
    localparam logic [5:0] OP_XOR = 6'h0E;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_NOR = 6'h0F;

    // True while the FSM owns an operation and cannot accept bytes
    function automatic logic is_busy_state(input seq_state_t s);
        return (s == ST_EXEC) || (s == ST_SETTLE) || (s == ST_SEND);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_timer.sv
// alu_seq_timer: clearable up-counter that flags the last cycle of an
// inter-byte timeout window. Used only when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_timer #(
    parameter int unsigned NB_TIMER       = 26,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [NB_TIMER-1:0] TC_LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMER-1:0] count;

    // Count enabled cycles; any clear restarts the window from zero
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + 1'b1;
        end
    end

    // A clear in the same cycle (byte arrival) suppresses expiry
    assign o_expired = i_enable && !i_clear && (count == TC_LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects A, B, OP bytes from the UART RX, strobes them
// into the ALU, captures the settled result and hands it to the UART TX.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer
    import alu_seq_pkg::*;
#(
    parameter int          NB_DATA        = 8,
    parameter int          NB_OPERATION   = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned NB_TIMER       = 26
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic [2:0]         o_alu_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_drop,
    output logic               o_timeout
);

    if (NB_OPERATION > NB_DATA || NB_OPERATION < 1) begin : g_bad_nb_operation
        $error("NB_OPERATION must be between 1 and NB_DATA");
    end
    if (longint'(TIMEOUT_CYCLES) > (longint'(1) << NB_TIMER) || TIMEOUT_CYCLES < 1) begin : g_bad_nb_timer
        $error("NB_TIMER too narrow for TIMEOUT_CYCLES");
    end

    seq_state_t         state;
    logic [NB_DATA-1:0] result;
    logic               timer_expired;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic timer_run;
    logic timer_clear;

    // Timer only runs while waiting for B or OP; leaving those states or
    // accepting a byte restarts it
    assign timer_run   = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign timer_clear = !timer_run || i_rx_valid;

    alu_seq_timer #(
        .NB_TIMER       (NB_TIMER),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (timer_clear),
        .i_enable  (timer_run),
        .o_expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // Sequencer FSM with all outputs registered
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_WAIT_A;
            o_alu_data  <= '0;
            o_alu_valid <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_drop      <= 1'b0;
            o_timeout   <= 1'b0;
            result      <= '0;
        end else begin
            o_alu_valid <= '0;
            o_tx_start  <= 1'b0;
            o_timeout   <= 1'b0;
            o_drop      <= i_rx_valid && is_busy_state(state);

            case (state)
                ST_WAIT_A: begin
                    if (i_rx_valid) begin
                        o_alu_data  <= i_rx_data;
                        o_alu_valid <= LOAD_A;
                        state       <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_valid) begin
                        o_alu_data  <= i_rx_data;
                        o_alu_valid <= LOAD_B;
                        state       <= ST_WAIT_OP;
                    end else if (timer_expired) begin
                        o_timeout <= 1'b1;
                        state     <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_valid) begin
                        o_alu_data  <= i_rx_data;
                        o_alu_valid <= LOAD_OP;
                        o_busy      <= 1'b1;
                        state       <= ST_EXEC;
                    end else if (timer_expired) begin
                        o_timeout <= 1'b1;
                        state     <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    result <= i_alu_result;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        o_tx_data  <= result;
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= ST_WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer. Stimulus pushes expected ALU
// strobes and TX bytes into queues; a negedge monitor pops and compares.
// Define ALU_SEQ_TIMEOUT_EN to exercise the timeout path.
module tb_alu_uart_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 100;
`else
    localparam int unsigned TO_CYCLES = 50000000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_data;
    logic [2:0] alu_valid;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       busy;
    logic       drop;
    logic       timeout;

    always #5 clk = ~clk;

    alu_uart_sequencer #(
        .NB_DATA        (8),
        .NB_OPERATION   (6),
        .TIMEOUT_CYCLES (TO_CYCLES),
        .NB_TIMER       (26)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_alu_data   (alu_data),
        .o_alu_valid  (alu_valid),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_drop       (drop),
        .o_timeout    (timeout)
    );

    // Behavioural ALU: registered operands, combinational result
    logic [7:0] ra, rb;
    logic [5:0] rop;
    always @(posedge clk) begin
        if (rst) begin
            ra <= '0; rb <= '0; rop <= '0;
        end else begin
            if (alu_valid[0]) ra  <= alu_data;
            if (alu_valid[1]) rb  <= alu_data;
            if (alu_valid[2]) rop <= alu_data[5:0];
        end
    end
    always_comb begin
        case (rop)
            6'h08:   alu_result = ra + rb;
            6'h0A:   alu_result = ra - rb;
            6'h0C:   alu_result = ra & rb;
            6'h0D:   alu_result = ra | rb;
            6'h0E:   alu_result = ra ^ rb;
            6'h02:   alu_result = ra >> rb;
            6'h03:   alu_result = 8'($signed(ra) >>> rb);
            6'h0F:   alu_result = ~(ra | rb);
            default: alu_result = 8'hFF;
        endcase
    end

    typedef struct { logic [2:0] v; logic [7:0] d; } strobe_t;
    typedef struct { logic [7:0] d; bit chk_lat; } tx_t;
    strobe_t sq[$];
    tx_t     tq[$];

    int checks = 0;
    int fails = 0;
    int drops_seen = 0;
    int timeouts_seen = 0;
    int cyc = 0;
    int op_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every strobe and TX start against the scoreboard
    always @(negedge clk) begin
        strobe_t s;
        tx_t     t;
        if (alu_valid != 3'b000) begin
            check("strobe_onehot", 32'($countones(alu_valid)), 32'd1);
            if (sq.size() == 0) begin
                checks++; fails++;
                $display("FAIL strobe_unexpected: got v=%b d=0x%0h expected none", alu_valid, alu_data);
            end else begin
                s = sq.pop_front();
                check("strobe_valid", 32'(alu_valid), 32'(s.v));
                check("strobe_data", 32'(alu_data), 32'(s.d));
            end
            if (alu_valid == 3'b100) op_cyc = cyc;
        end
        if (tx_start) begin
            if (tq.size() == 0) begin
                checks++; fails++;
                $display("FAIL tx_unexpected: got 0x%0h expected none", tx_data);
            end else begin
                t = tq.pop_front();
                check("tx_data", 32'(tx_data), 32'(t.d));
                if (t.chk_lat) check("tx_latency", 32'(cyc - op_cyc), 32'd3);
            end
        end
        if (drop) drops_seen++;
        if (timeout) timeouts_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_strobe(input logic [2:0] v, input logic [7:0] d);
        strobe_t s;
        s.v = v; s.d = d;
        sq.push_back(s);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input bit chk_lat);
        tx_t t;
        push_strobe(3'b001, a);
        push_strobe(3'b010, b);
        push_strobe(3'b100, op);
        t.d = exp; t.chk_lat = chk_lat;
        tq.push_back(t);
        send(a); send(b); send(op);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tq.size() != 0 || busy) && n < 200) begin
            tick(1);
            n++;
        end
        check("wait_idle_bound", 32'(tq.size() != 0 || busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_data"}, 32'(alu_data), 32'd0);
        check({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(drop), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx_data = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Basic ops with ready high: latency checked
        triplet(8'h05, 8'h03, 8'h08, 8'h08, 1'b1);
        wait_idle();
        check("tx_hold_after_send", 32'(tx_data), 32'h08);
        triplet(8'h03, 8'h05, 8'h0A, 8'hFE, 1'b1);
        wait_idle();
        triplet(8'h01, 8'h01, 8'h3F, 8'hFF, 1'b1);
        wait_idle();
        triplet(8'hF0, 8'h3C, 8'h0E, 8'hCC, 1'b1);
        wait_idle();
        triplet(8'h80, 8'h02, 8'h03, 8'hE0, 1'b1);
        wait_idle();

        // Backpressure: SEND must hold with previous tx byte stable
        tx_ready = 1'b0;
        triplet(8'h05, 8'h03, 8'h08, 8'h08, 1'b0);
        tick(3);
        for (int i = 0; i < 20; i++) begin
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_tx_stable", 32'(tx_data), 32'hE0);
            tick(1);
        end
        check("bp_pending", 32'(tq.size()), 32'd1);
        tx_ready = 1'b1;
        wait_idle();
        check("bp_tx_after", 32'(tx_data), 32'h08);
        tick(3);

        // Drop: extra byte during EXEC is discarded
        triplet(8'h11, 8'h22, 8'h08, 8'h33, 1'b1);
        check("drop_busy", 32'(busy), 32'd1);
        send(8'h77);
        wait_idle();
        check("drop_count", 32'(drops_seen), 32'd1);
        triplet(8'h10, 8'h20, 8'h0D, 8'h30, 1'b1);
        wait_idle();

        // Reset mid-sequence
        push_strobe(3'b001, 8'h05);
        push_strobe(3'b010, 8'h03);
        send(8'h05);
        send(8'h03);
        rst = 1'b1;
        tick(1);
        check_all_zero("midreset");
        rst = 1'b0;
        triplet(8'h02, 8'h02, 8'h08, 8'h04, 1'b1);
        wait_idle();

`ifdef ALU_SEQ_TIMEOUT_EN
        // Timeout: A byte then silence for the full window
        push_strobe(3'b001, 8'h05);
        send(8'h05);
        tick(99);
        check("timeout_not_early", 32'(timeouts_seen), 32'd0);
        tick(2);
        check("timeout_pulse", 32'(timeouts_seen), 32'd1);
        tick(2);
        check("timeout_single", 32'(timeouts_seen), 32'd1);
        triplet(8'h09, 8'h01, 8'h08, 8'h0A, 1'b1);
        wait_idle();
`else
        // Without the timeout feature WAIT_B waits indefinitely
        push_strobe(3'b001, 8'h05);
        send(8'h05);
        tick(120);
        check("no_timeout", 32'(timeouts_seen), 32'd0);
        begin
            tx_t t;
            push_strobe(3'b010, 8'h06);
            push_strobe(3'b100, 8'h08);
            t.d = 8'h0B; t.chk_lat = 1'b1;
            tq.push_back(t);
            send(8'h06);
            send(8'h08);
        end
        wait_idle();
`endif

        tick(5);
        check("strobe_queue_empty", 32'(sq.size()), 32'd0);
        check("tx_queue_empty", 32'(tq.size()), 32'd0);
        check("drop_total", 32'(drops_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
- Sits between the UART receiver/transmitter and the ALU. Consumes received bytes in order A, B, OP.
- Drives the ALU's shared data bus and one-hot 3-bit load strobe (bit0=A, bit1=B, bit2=OP).
- After the ALU settles, captures its combinational result and hands it to the UART TX with a start/ready handshake, then rearms for the next triplet.

Parameters:
- NB_DATA, 8, width of rx byte, ALU operands and result.
- NB_OPERATION, 6, width of ALU op field; must be <= NB_DATA.
- TIMEOUT_CYCLES, 50000000, inter-byte timeout in clocks (used only with ALU_SEQ_TIMEOUT_EN).
- NB_TIMER, 26, timer width; must hold TIMEOUT_CYCLES.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_rx_data  input  NB_DATA  received byte, valid when i_rx_valid=1.
- i_rx_valid  input  1  one-cycle pulse per received byte.
- o_alu_data  output  NB_DATA  data bus to ALU.
- o_alu_valid  output  3  one-hot load strobe to ALU.
- i_alu_result  input  NB_DATA  ALU combinational result.
- o_tx_data  output  NB_DATA  result byte to UART TX.
- o_tx_start  output  1  one-cycle transmit request.
- i_tx_ready  input  1  TX idle and able to accept a byte.
- o_busy  output  1  high in EXEC, SETTLE, SEND.
- o_drop  output  1  one-cycle pulse when a byte is discarded.
- o_timeout  output  1  one-cycle pulse on timeout abort; constant 0 without macro.

Behaviour:
- Clock and reset: one clock, i_clock. i_reset is synchronous and active-high.
- Reset state: all outputs registered. State=WAIT_A; o_alu_data=0, o_alu_valid=3'b000, o_tx_data=0, o_tx_start=0, o_busy=0, o_drop=0, o_timeout=0, result register=0.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SETTLE, SEND.
- WAIT_A/WAIT_B/WAIT_OP: on i_rx_valid, register o_alu_data=i_rx_data and o_alu_valid=001/010/100 for exactly one cycle, then advance. WAIT_OP advances to EXEC.
- o_alu_valid returns to 000 in every cycle with no strobe. Never more than one bit set.
- o_alu_data holds its last value between strobes.
- EXEC: one cycle while the ALU registers the op.
- SETTLE: capture i_alu_result into the result register, then go to SEND.
- Latency: OP byte accepted at edge k -> strobe high in cycle k+1 -> ALU op updated at edge k+2 -> result captured at edge k+3.
- SEND, i_tx_ready=1: drive o_tx_data=result, pulse o_tx_start for one cycle, return to WAIT_A.
- SEND, i_tx_ready=0: stay in SEND with o_tx_start=0 and o_tx_data stable.
- o_tx_data keeps the last result after send.
- i_rx_valid in EXEC, SETTLE or SEND: byte discarded, o_drop pulses next cycle, no state change.
- Reset mid-sequence: pending operands, result and pending send are abandoned; state returns to WAIT_A. ALU registers are reset by their own reset.
- The op byte is passed whole on o_alu_data; the ALU uses its low NB_OPERATION bits.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - Timer counts clocks in WAIT_B and WAIT_OP; it clears on every accepted byte and on entry to WAIT_A.
  - When the timer reaches TIMEOUT_CYCLES-1 with no byte: return to WAIT_A, pulse o_timeout for one cycle.
  - Already-loaded ALU operands are not cleared.
  - A byte arriving in the same cycle as expiry wins: it is accepted and no timeout occurs.
- Not defined: no timer logic; o_timeout tied 0; WAIT states wait indefinitely.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding localparams;
  - strobe one-hot constants LOAD_A=3'b001, LOAD_B=3'b010, LOAD_OP=3'b100, shared with the ALU's bench;
  - ALU op code constants: ADD 8, SUB 0x0A, AND 0x0C, OR 0x0D, XOR 0x0E, SRL 0x02, SRA 0x03, NOR 0x0F.
- One natural sub-module: alu_seq_timer, a clearable up-counter with terminal-count pulse, instantiated only under ALU_SEQ_TIMEOUT_EN.

Test Plan:
- ADD: rx 0x05, 0x03, 0x08 with i_tx_ready=1 -> strobes 001/010/100 with data 05/03/08; o_tx_start pulses with o_tx_data=0x08 three cycles after the OP strobe.
- SUB wrap: rx 0x03, 0x05, 0x0A -> o_tx_data=0xFE. Invalid op: rx 0x01, 0x01, 0x3F -> o_tx_data=0xFF.
- Backpressure: hold i_tx_ready=0 for 20 cycles after ADD triplet -> stays in SEND, o_busy=1, o_tx_data stable; raise ready -> single o_tx_start.
- Drop: send a 4th byte 0x77 while o_busy=1 -> o_drop pulses once; the next triplet is processed normally with 0x77 not used as A.
- Reset mid-op: rx 0x05, 0x03, then i_reset for 1 cycle -> all outputs 0, state WAIT_A; the next triplet 0x02, 0x02, 0x08 yields 0x04.
- Timeout (macro on, TIMEOUT_CYCLES=100): rx 0x05 then idle 100 cycles -> o_timeout pulses; next byte 0x09 is strobed as A (001).
